// File: rtl/center_of_mass_pkg.sv
// Shared defaults and FSM state encoding for the centroid engine.
package com_pkg;

  localparam int HWIDTH_DEF    = 11;
  localparam int VWIDTH_DEF    = 10;
  localparam int ACC_WIDTH_DEF = 32;

  typedef enum logic {
    ACCUM,
    DIVIDE
  } state_t;

endpackage

// File: rtl/center_of_mass_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, done pulse when the last bit lands.
module divider
  import com_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [ACC_WIDTH-1:0] dividend_in,
  input  logic [ACC_WIDTH-1:0] divisor_in,
  input  logic                 data_valid_in,
  output logic [ACC_WIDTH-1:0] quotient_out,
  output logic [ACC_WIDTH-1:0] remainder_out,
  output logic                 data_valid_out,
  output logic                 busy_out
);

  localparam int CW = $clog2(ACC_WIDTH + 1);

  logic [ACC_WIDTH-1:0] rem;
  logic [ACC_WIDTH-1:0] quo;
  logic [ACC_WIDTH-1:0] den;
  logic [CW-1:0]        cnt;
  logic                 busy;
  logic                 done;

  logic [ACC_WIDTH:0]   shifted;
  logic [ACC_WIDTH:0]   diff;
  logic                 fits;

  // A zero divisor always "fits", so the quotient naturally comes out all-ones.
  assign shifted = {rem, quo[ACC_WIDTH-1]};
  assign diff    = shifted - {1'b0, den};
  assign fits    = ~diff[ACC_WIDTH];

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_in) begin
      rem  <= '0;
      quo  <= '0;
      den  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (data_valid_in && !busy) begin
        rem  <= '0;
        quo  <= dividend_in;
        den  <= divisor_in;
        cnt  <= CW'(ACC_WIDTH);
        busy <= 1'b1;
      end else if (busy) begin
        quo <= {quo[ACC_WIDTH-2:0], fits};
        rem <= fits ? diff[ACC_WIDTH-1:0] : shifted[ACC_WIDTH-1:0];
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient_out   = quo;
  assign remainder_out  = rem;
  assign data_valid_out = done;
  assign busy_out       = busy;

endmodule

// File: rtl/center_of_mass.sv
// Frame centroid: accumulates masked pixel sums, divides by pixel count at end of frame.
module center_of_mass
  import com_pkg::*;
#(
  parameter int HWIDTH    = HWIDTH_DEF,
  parameter int VWIDTH    = VWIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [HWIDTH-1:0] x_in,
  input  logic [VWIDTH-1:0] y_in,
  input  logic              valid_in,
  input  logic              tabulate_in,
  output logic [HWIDTH-1:0] x_out,
  output logic [VWIDTH-1:0] y_out,
  output logic              valid_out
);

  state_t state, state_next;

  logic [ACC_WIDTH-1:0] sum_x, sum_y, count;
  logic [ACC_WIDTH-1:0] sum_x_next, sum_y_next, count_next;
  logic [ACC_WIDTH-1:0] dividend_x, dividend_y, divisor;
  logic [ACC_WIDTH-1:0] quo_x, quo_y, rem_x, rem_y;
  logic                 div_start, done_x, done_y, busy_x, busy_y;
  logic                 seen_x, seen_y;
  logic                 start, finish;
  logic                 unused;

  // Sums including the current pixel, so a pixel coincident with tabulate_in joins the snapshot.
  assign sum_x_next = sum_x + (valid_in ? ACC_WIDTH'(x_in) : '0);
  assign sum_y_next = sum_y + (valid_in ? ACC_WIDTH'(y_in) : '0);
  assign count_next = count + ACC_WIDTH'(valid_in);

  always_comb begin
    // NOTE: defaults first so no path leaves a combinational signal unassigned (no latches).
    state_next = state;
    start      = 1'b0;
    finish     = 1'b0;
    case (state)
      ACCUM: begin
        if (tabulate_in && count_next != '0) begin
          state_next = DIVIDE;
          start      = 1'b1;
        end
      end
      DIVIDE: begin
        if (seen_x && seen_y) begin
          state_next = ACCUM;
          finish     = 1'b1;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sum_x      <= '0;
      sum_y      <= '0;
      count      <= '0;
      dividend_x <= '0;
      dividend_y <= '0;
      divisor    <= '0;
      div_start  <= 1'b0;
      seen_x     <= 1'b0;
      seen_y     <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      valid_out  <= 1'b0;
    end else begin
      // Tabulate always closes the frame, even while a division is running (frame dropped).
      if (tabulate_in) begin
        sum_x <= '0;
        sum_y <= '0;
        count <= '0;
      end else begin
        sum_x <= sum_x_next;
        sum_y <= sum_y_next;
        count <= count_next;
      end

      div_start <= start;
      if (start) begin
        dividend_x <= sum_x_next;
        dividend_y <= sum_y_next;
        divisor    <= count_next;
        seen_x     <= 1'b0;
        seen_y     <= 1'b0;
      end else begin
        if (done_x) seen_x <= 1'b1;
        if (done_y) seen_y <= 1'b1;
      end

      valid_out <= finish;
      if (finish) begin
        x_out <= quo_x[HWIDTH-1:0];
        y_out <= quo_y[VWIDTH-1:0];
      end
    end
  end

  divider #(.ACC_WIDTH(ACC_WIDTH)) u_div_x (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .dividend_in   (dividend_x),
    .divisor_in    (divisor),
    .data_valid_in (div_start),
    .quotient_out  (quo_x),
    .remainder_out (rem_x),
    .data_valid_out(done_x),
    .busy_out      (busy_x)
  );

  divider #(.ACC_WIDTH(ACC_WIDTH)) u_div_y (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .dividend_in   (dividend_y),
    .divisor_in    (divisor),
    .data_valid_in (div_start),
    .quotient_out  (quo_y),
    .remainder_out (rem_y),
    .data_valid_out(done_y),
    .busy_out      (busy_y)
  );

  assign unused = ^{rem_x, rem_y, busy_x, busy_y,
                    quo_x[ACC_WIDTH-1:HWIDTH], quo_y[ACC_WIDTH-1:VWIDTH]};

endmodule

// File: tb/tb_center_of_mass.sv
// Scoreboard bench for center_of_mass: a frame model queues expected centroids, a monitor checks them.
module tb_center_of_mass;

  localparam int H   = 11;
  localparam int V   = 10;
  localparam int A   = 32;
  localparam int LAT = A + 3;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b1;
  logic [H-1:0] x_in = '0;
  logic [V-1:0] y_in = '0;
  logic         valid_in = 1'b0;
  logic         tabulate_in = 1'b0;
  logic [H-1:0] x_out;
  logic [V-1:0] y_out;
  logic         valid_out;

  center_of_mass #(.HWIDTH(H), .VWIDTH(V), .ACC_WIDTH(A)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .x_in       (x_in),
    .y_in       (y_in),
    .valid_in   (valid_in),
    .tabulate_in(tabulate_in),
    .x_out      (x_out),
    .y_out      (y_out),
    .valid_out  (valid_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    int x;
    int y;
    int tab_edge;
  } exp_t;

  exp_t   sb[$];
  exp_t   e;
  int     edge_num   = 0;
  longint msx        = 0;
  longint msy        = 0;
  longint mcnt       = 0;
  int     busy_until = -1;
  int     last_x     = 0;
  int     last_y     = 0;
  logic   prev_valid = 1'b0;

  // One clock: drive on the falling edge, then mirror the sampled edge in the frame model.
  task automatic step(input int x, input int y, input bit v, input bit tab, input bit rst);
    @(negedge clk_in);
    x_in        = H'(x);
    y_in        = V'(y);
    valid_in    = v;
    tabulate_in = tab;
    rst_in      = rst;
    @(posedge clk_in);
    edge_num++;
    if (rst) begin
      msx = 0; msy = 0; mcnt = 0;
      busy_until = -1;
      sb.delete();
    end else begin
      if (v) begin
        msx += x; msy += y; mcnt++;
      end
      if (tab) begin
        if (edge_num > busy_until && mcnt != 0) begin
          sb.push_back('{int'(msx / mcnt), int'(msy / mcnt), edge_num});
          busy_until = edge_num + LAT;
        end
        msx = 0; msy = 0; mcnt = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3 * LAT) begin
      step(0, 0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    idle(2);
  endtask

  always @(negedge clk_in) begin
    if (valid_out) begin
      check("double_valid", prev_valid, 0);
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("x_out", x_out, e.x);
        check("y_out", y_out, e.y);
        check("latency", edge_num - e.tab_edge, LAT);
        last_x = e.x;
        last_y = e.y;
      end
    end
    prev_valid = valid_out;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    step(0, 0, 1'b0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk_in);
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_valid", valid_out, 0);

    // Single pixel.
    step(100, 50, 1'b1, 1'b0, 1'b0);
    idle(3);
    step(0, 0, 1'b0, 1'b1, 1'b0);
    drain();

    // Three pixels, last one coincident with tabulate; floor division.
    step(10, 20, 1'b1, 1'b0, 1'b0);
    step(11, 20, 1'b1, 1'b0, 1'b0);
    step(13, 23, 1'b1, 1'b1, 1'b0);
    drain();

    // Empty frame: no result, outputs hold.
    step(0, 0, 1'b0, 1'b1, 1'b0);
    idle(60);
    check("hold_x", x_out, last_x);
    check("hold_y", y_out, last_y);

    // Frame corners plus a full row at y=0 (quotient lands on a .5 boundary).
    step(0, 0, 1'b1, 1'b0, 1'b0);
    step(1279, 0, 1'b1, 1'b0, 1'b0);
    step(0, 719, 1'b1, 1'b0, 1'b0);
    step(1279, 719, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 1280; i++) step(i, 0, 1'b1, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b1, 1'b0);
    drain();

    // Corners only.
    step(0, 0, 1'b1, 1'b0, 1'b0);
    step(1279, 0, 1'b1, 1'b0, 1'b0);
    step(0, 719, 1'b1, 1'b0, 1'b0);
    step(1279, 719, 1'b1, 1'b1, 1'b0);
    drain();

    // Second tabulate mid-division drops its frame; later pixels start a fresh frame.
    step(200, 100, 1'b1, 1'b0, 1'b0);
    step(300, 100, 1'b1, 1'b1, 1'b0);
    idle(9);
    step(500, 500, 1'b1, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b1, 1'b0);
    step(3, 4, 1'b1, 1'b0, 1'b0);
    drain();
    step(0, 0, 1'b0, 1'b1, 1'b0);
    drain();

    // Reset mid-division aborts it.
    step(40, 60, 1'b1, 1'b1, 1'b0);
    idle(5);
    step(0, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk_in);
    check("abort_x", x_out, 0);
    check("abort_y", y_out, 0);
    idle(60);
    check("abort_hold_x", x_out, 0);
    check("abort_hold_y", y_out, 0);
    step(7, 9, 1'b1, 1'b1, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/center_of_mass.md
Name: center_of_mass

Overview:
- Computes the centroid (x,y) of all thresholded (mask) pixels in one camera frame, feeding the crosshair generator that drives the video mux crosshair input.
- Accumulates pixel sums during the frame; on an end-of-frame pulse, launches two iterative divisions and emits one result per frame.

Parameters:
- HWIDTH, 11, width of pixel x coordinate
- VWIDTH, 10, width of pixel y coordinate
- ACC_WIDTH, 32, width of sum/count accumulators and divider operands

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- x_in  input  HWIDTH  x coordinate of current pixel
- y_in  input  VWIDTH  y coordinate of current pixel
- valid_in  input  1  current pixel is in mask; accumulate it
- tabulate_in  input  1  single-cycle end-of-frame pulse
- x_out  output  HWIDTH  centroid x, held until next result
- y_out  output  VWIDTH  centroid y, held until next result
- valid_out  output  1  one-cycle pulse when x_out/y_out update

Behaviour:
- Reset: x_out=0, y_out=0, valid_out=0, sums/count=0, state ACCUM, divider idle. Reset mid-division aborts it; no valid_out follows.
- Accumulators: sum_x += x_in, sum_y += y_in, count += 1 on each valid_in cycle. All ACC_WIDTH wide, zero-extended adds, no saturation (1280x720 full mask fits).
- States: ACCUM, DIVIDE.
- ACCUM + tabulate_in: snapshot sum_x, sum_y, count (including a valid_in pixel in the same cycle). Clear accumulators to 0 on the same edge.
  - If snapshot count==0: stay ACCUM, no valid_out, outputs unchanged.
  - Otherwise: start both dividers (sum_x/count, sum_y/count) and go to DIVIDE.
- Accumulation continues in every state. Pixels after the tabulate edge belong to the next frame.
- DIVIDE: wait until both divider done flags are seen. They finish together, but latch each done independently.
  - Then register x_out = quotient_x[HWIDTH-1:0] and y_out = quotient_y[VWIDTH-1:0] (floor division). Pulse valid_out for exactly one cycle and return to ACCUM.
- tabulate_in during DIVIDE: accumulators cleared (frame dropped). In-progress division is unaffected; no second division is queued.
- Latency: valid_out rises exactly ACC_WIDTH+3 edges after the edge sampling tabulate_in (35 at default).
- valid_out never asserts on two consecutive cycles.

Decomposition:
- Package com_pkg: HWIDTH/VWIDTH/ACC_WIDTH defaults and the state enum {ACCUM, DIVIDE}.
- Sub-module divider: restoring unsigned divider, ACC_WIDTH parameter.
  - Ports: clk_in, rst_in, dividend_in, divisor_in, data_valid_in (start), quotient_out, remainder_out, data_valid_out (done pulse), busy_out.
  - One quotient bit per cycle; done pulse ACC_WIDTH+1 cycles after start.
  - Divide by zero never occurs (guarded by count==0 check). Define the result anyway as quotient all-ones.
  - Instantiated twice.

Test Plan:
- Single pixel (x=100,y=50), then tabulate -> 35 cycles later valid_out=1 for one cycle, x_out=100, y_out=50.
- Pixels (10,20),(11,20),(13,23), tabulate -> x_out=11 (34/3 floor), y_out=21 (63/3).
- Tabulate with zero pixels -> valid_out stays 0 for 60 cycles; outputs keep previous frame's values.
- Full 1280x720 mask, tabulate -> x_out=639, y_out=359; no overflow.
- Tabulate again 10 cycles into DIVIDE, with pixels before it -> exactly one valid_out carrying the first frame result. The next frame's sums start at 0 from the second tabulate.
- Assert rst_in 5 cycles into DIVIDE -> no valid_out afterwards; outputs 0. The next frame (pixel (7,9)) yields 7,9 normally.
